// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and bit helpers
package uart_pkg;

  // Oversampling: ticks per bit and the tick index treated as mid-bit
  localparam int OSR_TICKS  = 16;
  localparam int MID_SAMPLE = 7;

  // Data bits per 8N1 frame
  localparam int FRAME_BITS = 8;

  // sysclk cycles per oversample tick (50 MHz / (16 * 9600))
  localparam int DEFAULT_TICK_DIV = 326;

  // Receiver FSM encoding; the transmitter reuses the same width
  typedef logic [1:0] uart_state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Bits arrive LSB first: each new bit enters at the MSB and the byte moves right
  function automatic logic [FRAME_BITS-1:0] shift_in_lsb_first(
    input logic [FRAME_BITS-1:0] sr,
    input logic                  bit_in
  );
    return {bit_in, sr[FRAME_BITS-1:1]};
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running single-cycle oversample tick enable
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic sysclk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV);
  localparam logic [CW-1:0] CNT_MIN = CW'(1);

  logic [CW-1:0] cnt;

  // Count 1..TICK_DIV and wrap; never restarted by frame activity
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt <= CNT_MIN;
    end else if (cnt == CNT_MAX) begin
      cnt <= CNT_MIN;
    end else begin
      cnt <= cnt + CNT_MIN;
    end
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/uart_rx_16x.sv
// rtl/uart_rx_16x.sv - 16x oversampling 8N1 UART receiver with ready/ack handshake
module uart_rx_16x
  import uart_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int OSR      = OSR_TICKS
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [3:0] LAST_TICK = 4'(OSR - 1);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE);
  localparam logic [2:0] LAST_BIT  = 3'(FRAME_BITS - 1);

  logic        tick;
  logic        rx_meta;
  logic        rxs;
  uart_state_t state;
  logic [3:0]  tcnt;
  logic [2:0]  bcnt;
  logic [7:0]  shreg;
  logic        stop_sample;
  logic        load;
  logic        ferr_evt;

  baud_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .tick   (tick)
  );

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Frame sequencer: moves only on ticks, samples at mid-bit
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      tcnt  <= 4'd0;
      bcnt  <= 3'd0;
      shreg <= 8'h00;
    end else if (tick) begin
      case (state)
        ST_IDLE: begin
          tcnt <= 4'd0;
          if (!rxs) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (tcnt == MID_TICK) begin
            // A line that is high again at mid-start was only a glitch
            if (rxs) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_DATA;
              tcnt  <= 4'd0;
              bcnt  <= 3'd0;
            end
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        ST_DATA: begin
          if (tcnt == LAST_TICK) begin
            shreg <= shift_in_lsb_first(shreg, rxs);
            bcnt  <= bcnt + 3'd1;
            tcnt  <= 4'd0;
            if (bcnt == LAST_BIT) begin
              state <= ST_STOP;
            end
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        default: begin
          // Leave at mid-stop so a following start edge is not missed
          if (tcnt == LAST_TICK) begin
            state <= ST_IDLE;
            tcnt  <= 4'd0;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
      endcase
    end
  end

  assign stop_sample = tick && (state == ST_STOP) && (tcnt == LAST_TICK);
  assign load        = stop_sample && rxs;
  assign ferr_evt    = stop_sample && !rxs;
  assign busy        = (state != ST_IDLE);

  // Output registers: a new byte beats a simultaneous ack, newest byte overwrites
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_data   <= 8'h00;
      rx_ready  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= ferr_evt;
      if (load) begin
        rx_data  <= shreg;
        rx_ready <= 1'b1;
      end else if (rx_ack) begin
        rx_ready <= 1'b0;
      end
      if (load && rx_ready && !rx_ack) begin
        overrun <= 1'b1;
      end else if (rx_ack) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
